// File: rtl/sar_search_pkg.sv
// Shared encodings for the successive-approximation searcher.
package sar_search_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Comparator response codes, ordered {agb, alb, aeb}
    localparam logic [2:0] CODE_GT = 3'b100;
    localparam logic [2:0] CODE_LT = 3'b010;
    localparam logic [2:0] CODE_EQ = 3'b001;

endpackage

// File: rtl/sar_code_check.sv
// Decodes the comparator response into one-hot flags and an illegal-code flag.
module sar_code_check
    import sar_search_pkg::*;
(
    input  logic agb,
    input  logic alb,
    input  logic aeb,
    output logic gt,
    output logic lt,
    output logic eq,
    output logic illegal
);

    logic [2:0] code;

    assign code = {agb, alb, aeb};

    // Only exactly-one-hot codes are meaningful; everything else is illegal
    always_comb begin
        gt      = (code == CODE_GT);
        lt      = (code == CODE_LT);
        eq      = (code == CODE_EQ);
        illegal = !(gt || lt || eq);
    end

endmodule

// File: rtl/sar_search.sv
// Successive-approximation searcher: drives a probe into an external magnitude
// comparator and resolves the hidden target MSB first, one bit per clock.
module sar_search
    import sar_search_pkg::*;
#(
    parameter  int W  = 3,
    localparam int SW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          agb,
    input  logic          alb,
    input  logic          aeb,
    output logic [W-1:0]  probe,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  result,
    output logic [SW-1:0] steps
);

    localparam logic [W-1:0]  MSB_ONLY = W'(1) << (W - 1);
    localparam logic [SW-1:0] IDX_TOP  = SW'(W - 1);

    state_t        state_q, state_d;
    logic [W-1:0]  probe_q, probe_d;
    logic [W-1:0]  result_q, result_d;
    logic [SW-1:0] steps_q, steps_d;
    logic [SW-1:0] idx_q, idx_d;
    logic          err_q, err_d;

    logic          c_gt, c_lt, c_eq, c_illegal;
    logic [W-1:0]  bit_mask;
    logic [W-1:0]  trial;

    sar_code_check u_code_check (
        .agb     (agb),
        .alb     (alb),
        .aeb     (aeb),
        .gt      (c_gt),
        .lt      (c_lt),
        .eq      (c_eq),
        .illegal (c_illegal)
    );

    // Bit under test, and the probe after applying this cycle's decision to it
    always_comb begin
        bit_mask = W'(1) << idx_q;
        trial    = c_lt ? (probe_q & ~bit_mask) : probe_q;
    end

    // Next-state and datapath decisions for the search
    always_comb begin
        state_d  = state_q;
        probe_d  = probe_q;
        result_d = result_q;
        steps_d  = steps_q;
        idx_d    = idx_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    probe_d  = MSB_ONLY;
                    idx_d    = IDX_TOP;
                    steps_d  = '0;
                    err_d    = 1'b0;
                    result_d = '0;
                    state_d  = S_PROBE;
                end
            end

            S_PROBE: begin
                steps_d = steps_q + SW'(1);
                if (c_illegal) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end else if (c_eq) begin
                    result_d = probe_q;
                    state_d  = S_DONE;
                end else if (c_gt && (idx_q == '0)) begin
                    // Target above a probe whose LSB is already set cannot happen
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_DONE;
                end else if (idx_q == '0) begin
                    // Only reachable on alb: the LSB is cleared and the search ends
                    probe_d  = trial;
                    result_d = trial;
                    state_d  = S_DONE;
                end else begin
                    probe_d  = trial | (bit_mask >> 1);
                    idx_d    = idx_q - SW'(1);
                end
            end

            S_DONE: begin
                probe_d = '0;
                state_d = S_IDLE;
            end

            default: begin
                probe_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously on rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            probe_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            steps_q  <= steps_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == S_PROBE);
    assign done   = (state_q == S_DONE);
    assign probe  = probe_q;
    assign result = result_q;
    assign steps  = steps_q;
    assign err    = err_q;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: behavioural comparator closes the loop,
// a closed-form search model predicts every output each cycle.
module tb_sar_search;

    localparam int W  = 3;
    localparam int SW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          agb, alb, aeb;
    logic [W-1:0]  probe;
    logic          busy, done, err;
    logic [W-1:0]  result;
    logic [SW-1:0] steps;

    int            target = 0;
    bit            force_en = 1'b0;
    logic [2:0]    fcode = 3'b000;

    int checks = 0;
    int failures = 0;

    int plog[$];

    sar_search #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .agb    (agb),
        .alb    (alb),
        .aeb    (aeb),
        .probe  (probe),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result),
        .steps  (steps)
    );

    always #5 clk = ~clk;

    // Behavioural comparator: a = target, b = probe, optionally overridden
    always_comb begin
        if (force_en) {agb, alb, aeb} = fcode;
        else {agb, alb, aeb} = {target > int'(probe), target < int'(probe), target == int'(probe)};
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- closed-form model of a search ----------------
    // Binary search halts at the probe whose single trailing one lands on the
    // target's lowest set bit, so probe count is W - ctz(target), or W for 0.
    function automatic int k_honest(input int t);
        if (t == 0) return W;
        for (int i = 0; i < W; i++) if (t[i]) return W - i;
        return W;
    endfunction

    // Target the probes behave as if chasing; forced codes mimic a fixed target
    function automatic int vt_of(input int t, input bit f, input logic [2:0] c);
        if (!f) return t;
        if (c == 3'b001) return 1 << (W - 1);
        if (c == 3'b100) return (1 << W) - 1;
        return 0;
    endfunction

    function automatic int k_of(input int t, input bit f, input logic [2:0] c);
        if (!f) return k_honest(t);
        if (c == 3'b010 || c == 3'b100) return W;
        return 1;
    endfunction

    function automatic int res_of(input int t, input bit f, input logic [2:0] c);
        if (!f) return t;
        if (c == 3'b001) return 1 << (W - 1);
        return 0;
    endfunction

    function automatic bit err_of(input bit f, input logic [2:0] c);
        return f && !(c == 3'b001 || c == 3'b010);
    endfunction

    // n-th probe: the target's top n bits, then a trial one, then zeros
    function automatic int exp_probe(input int vt, input int n);
        int sh;
        sh = W - n;
        return ((vt >> sh) << sh) | (1 << (W - 1 - n));
    endfunction

    int m_ph = 0;      // 0 idle, 1 searching, 2 done cycle
    int m_n = 0;       // probes already answered in this search
    int m_k = 0;
    int m_vt = 0;
    int m_fres = 0;
    bit m_ferr = 1'b0;
    int m_result = 0;
    int m_steps = 0;
    bit m_err = 1'b0;

    // Model progression: one probe answered per edge, done lasts one cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= 0; m_n <= 0; m_k <= 0; m_vt <= 0;
            m_result <= 0; m_steps <= 0; m_err <= 1'b0;
        end else if (m_ph == 2) begin
            m_ph <= 0;
        end else if (m_ph == 1) begin
            m_n <= m_n + 1;
            m_steps <= m_n + 1;
            if (m_n + 1 == m_k) begin
                m_ph <= 2;
                m_result <= m_fres;
                m_err <= m_ferr;
            end
        end else if (start) begin
            m_ph <= 1;
            m_n <= 0;
            m_k <= k_of(target, force_en, fcode);
            m_vt <= vt_of(target, force_en, fcode);
            m_fres <= res_of(target, force_en, fcode);
            m_ferr <= err_of(force_en, fcode);
            m_result <= 0;
            m_steps <= 0;
            m_err <= 1'b0;
        end
    end

    bit prev_done = 1'b0;

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_ph == 1));
        chk("done", int'(done), int'(m_ph == 2));
        chk("err", int'(err), int'(m_err));
        chk("result", int'(result), m_result);
        chk("steps", int'(steps), m_steps);
        chk("done_pulse", int'(done && prev_done), 0);
        if (m_ph == 1) chk("probe", int'(probe), exp_probe(m_vt, m_n));
        if (m_ph == 0) chk("probe_idle", int'(probe), 0);
        if (busy) plog.push_back(int'(probe));
        prev_done <= done;
    end

    // ---------------- directed helpers ----------------
    task automatic run_search(input int t, input bit f, input logic [2:0] c, output bit ok);
        @(negedge clk); #1;
        target = t; force_en = f; fcode = c; start = 1'b1;
        plog.delete();
        @(negedge clk); #1;
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            failures++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", W + 4);
        end
        checks++;
    endtask

    task automatic chk_plog(input string nm, input int p0, input int p1, input int p2);
        chk(nm, plog.size(), 3);
        if (plog.size() == 3) begin
            chk(nm, plog[0], p0);
            chk(nm, plog[1], p1);
            chk(nm, plog[2], p2);
        end
    endtask

    initial begin
        bit ok;
        logic [2:0] bad_codes[5];
        bad_codes = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

        #1 rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_probe", int'(probe), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_steps", int'(steps), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // target 5: probes 100, 110, 101
        run_search(5, 1'b0, 3'b000, ok);
        chk("t5_result", int'(result), 5);
        chk("t5_steps", int'(steps), 3);
        chk("t5_err", int'(err), 0);
        chk_plog("t5_probes", 4, 6, 5);

        // target 4: equal on first probe
        run_search(4, 1'b0, 3'b000, ok);
        chk("t4_result", int'(result), 4);
        chk("t4_steps", int'(steps), 1);

        // target 0: all-alb path
        run_search(0, 1'b0, 3'b000, ok);
        chk("t0_result", int'(result), 0);
        chk("t0_steps", int'(steps), 3);
        chk_plog("t0_probes", 4, 2, 1);

        run_search(7, 1'b0, 3'b000, ok);
        chk("t7_result", int'(result), 7);
        chk_plog("t7_probes", 4, 6, 7);

        // illegal code on first probe
        run_search(5, 1'b1, 3'b011, ok);
        chk("bad_err", int'(err), 1);
        chk("bad_result", int'(result), 0);
        chk("bad_steps", int'(steps), 1);
        @(negedge clk);
        chk("bad_done_single", int'(done), 0);

        // following start clears err
        @(negedge clk); #1;
        force_en = 1'b0; target = 2; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk("err_cleared", int'(err), 0);
        repeat (W + 2) @(negedge clk);

        // agb at the last bit is inconsistent
        run_search(0, 1'b1, 3'b100, ok);
        chk("gt_lsb_err", int'(err), 1);
        chk("gt_lsb_steps", int'(steps), 3);

        foreach (bad_codes[i]) begin
            run_search(3, 1'b1, bad_codes[i], ok);
            chk("illegal_err", int'(err), 1);
        end

        // start during PROBE is ignored
        @(negedge clk); #1;
        force_en = 1'b0; target = 6; start = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("ign_result", int'(result), 6);
        chk("ign_steps", int'(steps), 2);
        chk("ign_busy", int'(busy), 0);

        // reset mid-search after the second probe
        @(negedge clk); #1;
        target = 3; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_probe", int'(probe), 0);
        chk("mid_rst_steps", int'(steps), 0);
        chk("mid_rst_result", int'(result), 0);
        @(negedge clk); #1;
        rst = 1'b0;

        // back-to-back sweep of every target
        for (int t = 0; t < (1 << W); t++) begin
            run_search(t, 1'b0, 3'b000, ok);
            chk("sweep_result", int'(result), t);
        end

        // randomized traffic, occasional resets and forced codes
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk); #1;
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 249) == 0) rst = 1'b1;
            if (m_ph != 1) begin
                target = $urandom_range(0, (1 << W) - 1);
                force_en = ($urandom_range(0, 7) == 0);
                fcode = 3'($urandom_range(0, 7));
            end
            start = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk); #1;
        start = 1'b0; rst = 1'b0; force_en = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
